// File: rtl/multicast_fwd_fifo.sv
// Multicast forwarding FIFO: each beat carries a destination mask and retires only
// once every addressed destination has accepted it; head state is held in output registers.
module multicast_fwd_fifo #(
  parameter int DATA_W = 256,
  parameter int N_DST  = 2,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_DST-1:0]  f_valid_in,
  input  logic [DATA_W-1:0] f_data_in,
  output logic              f_ready_out,
  output logic [N_DST-1:0]  b_valid_out,
  output logic [DATA_W-1:0] b_data_out,
  input  logic [N_DST-1:0]  b_ready_in,
  output logic [CNT_W-1:0]  fill_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N_DST-1:0]  mask_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [N_DST-1:0]  b_valid_q, b_valid_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;

  logic [N_DST-1:0]  acc_s;
  logic [N_DST-1:0]  pend_left_s;
  logic              not_empty_s;
  logic              push_s;
  logic              pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // b_valid_q always holds the head's pending mask, so a non-empty queue never shows zero
  always_comb begin
    acc_s       = b_valid_q & b_ready_in;
    pend_left_s = b_valid_q & ~acc_s;
    not_empty_s = (cnt_q != CNT_W'(0));
    push_s      = (|f_valid_in) & ready_q;
    pop_s       = not_empty_s & (pend_left_s == '0);
  end

  // Occupancy and pointer next-state
  always_comb begin
    rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    ready_d = (cnt_d != CNT_W'(DEPTH));
  end

  // Next head: the incoming beat when it becomes the only entry, else the stored successor
  always_comb begin
    b_valid_d = '0;
    b_data_d  = b_data_q;
    if (cnt_d == CNT_W'(0)) begin
      b_valid_d = '0;
    end else if (!not_empty_s || (pop_s && (cnt_q == CNT_W'(1)))) begin
      b_valid_d = f_valid_in;
      b_data_d  = f_data_in;
    end else if (!pop_s) begin
      b_valid_d = pend_left_s;
    end else begin
      b_valid_d = mask_mem[rd_ptr_d];
      b_data_d  = data_mem[rd_ptr_d];
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      b_valid_q <= '0;
      b_data_q  <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  // Entry storage, not reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mask_mem[wr_ptr_q] <= f_valid_in;
      data_mem[wr_ptr_q] <= f_data_in;
    end
  end

  assign f_ready_out = ready_q;
  assign b_valid_out = b_valid_q;
  assign b_data_out  = b_data_q;
  assign fill_cnt    = cnt_q;

endmodule

// File: tb/tb_multicast_fwd_fifo.sv
// Bench for multicast_fwd_fifo: directed scenarios plus random traffic, checked against
// a queue-of-beats reference model and per-destination expected-delivery scoreboards.
module tb_multicast_fwd_fifo;

  localparam int DATA_W = 32;
  localparam int N_DST  = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_DST-1:0]  f_valid_in = '0;
  logic [DATA_W-1:0] f_data_in = '0;
  logic              f_ready_out;
  logic [N_DST-1:0]  b_valid_out;
  logic [DATA_W-1:0] b_data_out;
  logic [N_DST-1:0]  b_ready_in = '0;
  logic [CNT_W-1:0]  fill_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [N_DST-1:0]  pend;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] exp_q [N_DST][$];

  beat_t       m_head;
  logic [3:0]  m_exp_v;
  logic        m_can_push;

  multicast_fwd_fifo #(.DATA_W(DATA_W), .N_DST(N_DST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid_in(f_valid_in), .f_data_in(f_data_in), .f_ready_out(f_ready_out),
    .b_valid_out(b_valid_out), .b_data_out(b_data_out), .b_ready_in(b_ready_in),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, score deliveries, then advance the model
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      for (int d = 0; d < N_DST; d++) exp_q[d].delete();
      check("rst_b_valid", 64'(b_valid_out), 64'(0));
      check("rst_fill_cnt", 64'(fill_cnt), 64'(0));
      check("rst_f_ready", 64'(f_ready_out), 64'(1));
    end else begin
      m_exp_v = (mq.size() != 0) ? mq[0].pend : 4'h0;
      check("b_valid", 64'(b_valid_out), 64'(m_exp_v));
      check("fill_cnt", 64'(fill_cnt), 64'(mq.size()));
      check("f_ready", 64'(f_ready_out), 64'(mq.size() != DEPTH));
      if (mq.size() != 0) check("b_data", 64'(b_data_out), 64'(mq[0].data));
      for (int d = 0; d < N_DST; d++) begin
        if (b_valid_out[d] && b_ready_in[d]) begin
          if (exp_q[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL deliver%0d: got beat %0h expected none at %0t", d, b_data_out, $time);
          end else begin
            check($sformatf("deliver%0d", d), 64'(b_data_out), 64'(exp_q[d].pop_front()));
          end
        end
      end
      m_can_push = (f_valid_in != 4'h0) && (mq.size() != DEPTH);
      if (mq.size() != 0) begin
        m_head = mq[0];
        m_head.pend = m_head.pend & ~b_ready_in;
        mq[0] = m_head;
        if (m_head.pend == 4'h0) void'(mq.pop_front());
      end
      if (m_can_push) begin
        m_head.pend = f_valid_in;
        m_head.data = f_data_in;
        mq.push_back(m_head);
        for (int d = 0; d < N_DST; d++)
          if (f_valid_in[d]) exp_q[d].push_back(f_data_in);
      end
    end
  end

  task automatic drive(input logic [3:0] m, input logic [31:0] dt, input logic [3:0] r);
    f_valid_in = m;
    f_data_in  = dt;
    b_ready_in = r;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  cm;
  logic [31:0] cd;
  logic        acc_prev;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'h0, 32'h0, 4'h0);

    // 1 single unicast
    drive(4'b0010, 32'hA5, 4'hF);
    drive(4'h0, 32'h0, 4'hF);
    drive(4'h0, 32'h0, 4'hF);

    // 2 staggered multicast
    drive(4'b1011, 32'h11, 4'h0);
    drive(4'h0, 32'h0, 4'b0001);
    drive(4'h0, 32'h0, 4'b1000);
    drive(4'h0, 32'h0, 4'b0010);
    drive(4'h0, 32'h0, 4'h0);

    // 3 full: fifth beat held until a slot frees
    for (int i = 0; i < 4; i++) drive(4'b0101, 32'h30 + 32'(i), 4'h0);
    drive(4'b0101, 32'h34, 4'h0);
    drive(4'b0101, 32'h34, 4'h0);
    drive(4'b0101, 32'h34, 4'hF);
    drive(4'b0101, 32'h34, 4'h0);
    drive(4'h0, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) drive(4'h0, 32'h0, 4'hF);

    // 4 streaming
    for (int i = 0; i < 16; i++) drive(4'hF, 32'(i), 4'hF);
    drive(4'h0, 32'h0, 4'hF);
    drive(4'h0, 32'h0, 4'hF);

    // 5 zero-mask cycles with toggling data, pointer wrap
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) drive(4'h0, $urandom, 4'hF);
      else drive(4'($urandom_range(1, 15)), 32'h500 + 32'(i), 4'hF);
    end
    drive(4'h0, 32'h0, 4'hF);

    // 6 reset with beats queued
    for (int i = 0; i < 3; i++) drive(4'hF, 32'h61 + 32'(i), 4'h0);
    f_valid_in = 4'h0;
    rst_n = 1'b0;
    #1;
    check("async_rst_fill_cnt", 64'(fill_cnt), 64'(0));
    check("async_rst_b_valid", 64'(b_valid_out), 64'(0));
    check("async_rst_f_ready", 64'(f_ready_out), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(4'h0, 32'h0, 4'hF);

    // random traffic, master holds an offer until accepted
    cm = 4'h0;
    cd = 32'h0;
    acc_prev = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (acc_prev || cm == 4'h0) begin
        cm = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        cd = $urandom;
      end
      acc_prev = (cm != 4'h0) && f_ready_out;
      drive(cm, cd, 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 8; i++) drive(4'h0, 32'h0, 4'hF);
    for (int d = 0; d < N_DST; d++)
      check($sformatf("drain%0d", d), 64'(exp_q[d].size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
